// File: rtl/tone_sequencer.sv
// Step-table melody controller that drives one clkgen voice through its maxval and silencing reset.
// Optional feature macro NOTE_SEQ_GAP_EN: adds a one-tick silent gap after every sounding note.
module tone_sequencer #(
    parameter int N      = 8,
    parameter int DUR_W  = 12,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N+DUR_W:0]  wr_data,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic              tick_i,
    output logic [N-1:0]      maxval_o,
    output logic              tone_rst_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] step_o,
    output logic              done_o
);
    localparam int WORD_W = 1 + N + DUR_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef NOTE_SEQ_GAP_EN
    localparam logic [2:0] S_GAP   = 3'd4;
`endif

    logic [WORD_W-1:0] r_table [DEPTH];
    logic [WORD_W-1:0] r_rd_word;
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_step;
    logic [DUR_W-1:0]  r_count;
    logic [N-1:0]      r_maxval;
    logic              r_tone_rst;
    logic              r_busy;
    logic              r_done;

    logic [2:0]        w_state_next;
    logic [ADDR_W-1:0] w_step_next;
    logic [DUR_W-1:0]  w_count_next;
    logic [N-1:0]      w_maxval_next;
    logic              w_tone_rst_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_advance;
    logic              w_finish;

    logic              w_rd_rest;
    logic [N-1:0]      w_rd_maxval;
    logic [DUR_W-1:0]  w_rd_dur;

    assign w_rd_rest   = r_rd_word[N+DUR_W];
    assign w_rd_maxval = r_rd_word[N+DUR_W-1:DUR_W];
    assign w_rd_dur    = r_rd_word[DUR_W-1:0];

    // Read-before-write: a same-cycle write to the fetched address yields the old word.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
        if (r_state == S_FETCH) begin
            r_rd_word <= r_table[r_step];
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_step_next     = r_step;
        w_count_next    = r_count;
        w_maxval_next   = r_maxval;
        w_tone_rst_next = r_tone_rst;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_advance       = 1'b0;
        w_finish        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    w_state_next = S_FETCH;
                    w_step_next  = '0;
                    w_busy_next  = 1'b1;
                end
            end
            S_FETCH: w_state_next = S_EVAL;
            S_EVAL: begin
                if (w_rd_dur == '0) begin
                    // A marker at step 0 always ends playback so an empty loop cannot spin.
                    if (r_step == '0 || !loop_i) begin
                        w_finish = 1'b1;
                    end else begin
                        w_step_next  = '0;
                        w_state_next = S_FETCH;
                    end
                end else begin
                    w_maxval_next   = w_rd_maxval;
                    w_tone_rst_next = w_rd_rest;
                    w_count_next    = w_rd_dur;
                    w_state_next    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick_i) begin
                    if (r_count == DUR_W'(1)) begin
`ifdef NOTE_SEQ_GAP_EN
                        if (!r_tone_rst) begin
                            w_tone_rst_next = 1'b1;
                            w_state_next    = S_GAP;
                        end else begin
                            w_advance = 1'b1;
                        end
`else
                        w_advance = 1'b1;
`endif
                    end else begin
                        w_count_next = r_count - DUR_W'(1);
                    end
                end
            end
`ifdef NOTE_SEQ_GAP_EN
            S_GAP: begin
                if (tick_i) begin
                    w_advance = 1'b1;
                end
            end
`endif
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        // Incrementing the all-ones step wraps to 0, which is exactly the loop restart.
        if (w_advance) begin
            if ((&r_step) && !loop_i) begin
                w_finish = 1'b1;
            end else begin
                w_step_next  = r_step + ADDR_W'(1);
                w_state_next = S_FETCH;
            end
        end

        if (stop_i && r_state != S_IDLE && r_state != S_DONE) begin
            w_finish = 1'b1;
        end

        // Finishing discards any note latched this cycle; maxval keeps its last value.
        if (w_finish) begin
            w_state_next    = S_DONE;
            w_step_next     = r_step;
            w_count_next    = r_count;
            w_maxval_next   = r_maxval;
            w_tone_rst_next = 1'b1;
            w_busy_next     = 1'b0;
            w_done_next     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_count    <= '0;
            r_maxval   <= '0;
            r_tone_rst <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_step     <= w_step_next;
            r_count    <= w_count_next;
            r_maxval   <= w_maxval_next;
            r_tone_rst <= w_tone_rst_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    assign maxval_o   = r_maxval;
    assign tone_rst_o = r_tone_rst;
    assign busy_o     = r_busy;
    assign step_o     = r_step;
    assign done_o     = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed and randomized checks of tone_sequencer against a tick-slot playback model.
module tb_tone_sequencer;
    localparam int N      = 8;
    localparam int DUR_W  = 12;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int WW     = 1 + N + DUR_W;

    logic              clk_i = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WW-1:0]     wr_data = '0;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic              loop_i = 1'b0;
    logic              tick_i = 1'b0;
    logic [N-1:0]      maxval_o;
    logic              tone_rst_o;
    logic              busy_o;
    logic [ADDR_W-1:0] step_o;
    logic              done_o;

    tone_sequencer #(.N(N), .DUR_W(DUR_W), .ADDR_W(ADDR_W)) u_dut (
        .clk_i(clk_i), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i), .tick_i(tick_i),
        .maxval_o(maxval_o), .tone_rst_o(tone_rst_o), .busy_o(busy_o),
        .step_o(step_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // One slot per tick: what the outputs must show while waiting for that tick.
    typedef struct {
        int step;
        int mv;
        bit rst;
    } slot_t;

    slot_t slots[$];
    bit    rest_m [DEPTH];
    int    mv_m   [DEPTH];
    int    dur_m  [DEPTH];
    bit    ends;
    int    hold_mv  = 0;
    int    done_cnt = 0;
    int    n_vec    = 0;
    int    n_err    = 0;

    always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void build(input bit lp, input int limit);
        int    s;
        slot_t t;
        s = 0;
        slots.delete();
        ends = 1'b0;
        while (slots.size() < limit) begin
            if (dur_m[s] == 0) begin
                if (s == 0 || !lp) begin
                    ends = 1'b1;
                    return;
                end
                s = 0;
            end else begin
                for (int k = 0; k < dur_m[s]; k++) begin
                    t.step = s; t.mv = mv_m[s]; t.rst = rest_m[s];
                    slots.push_back(t);
                end
`ifdef NOTE_SEQ_GAP_EN
                if (!rest_m[s]) begin
                    t.step = s; t.mv = mv_m[s]; t.rst = 1'b1;
                    slots.push_back(t);
                end
`endif
                if (s == DEPTH - 1) begin
                    if (!lp) begin
                        ends = 1'b1;
                        return;
                    end
                    s = 0;
                end else begin
                    s++;
                end
            end
        end
    endfunction

    task automatic settle();
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic wr_raw(input int a, input logic [WW-1:0] w);
        @(posedge clk_i); #1;
        wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = w;
        @(posedge clk_i); #1;
        wr_en = 1'b0;
    endtask

    task automatic wr_step(input int a, input bit r, input int mv, input int dur);
        rest_m[a] = r; mv_m[a] = mv; dur_m[a] = dur;
        wr_raw(a, {r, N'(mv), DUR_W'(dur)});
    endtask

    task automatic tick(input bit also_start);
        @(posedge clk_i); #1;
        tick_i = 1'b1; start_i = also_start;
        @(posedge clk_i); #1;
        tick_i = 1'b0; start_i = 1'b0;
        settle();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_maxval"}, 32'(maxval_o), 0);
        chk({tag, "_tone_rst"}, 32'(tone_rst_o), 1);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_step"}, 32'(step_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
    endtask

    task automatic chk_slot(input string tag, input int i);
        chk({tag, "_step"}, 32'(step_o), 32'(slots[i].step));
        chk({tag, "_maxval"}, 32'(maxval_o), 32'(slots[i].mv));
        chk({tag, "_tone_rst"}, 32'(tone_rst_o), 32'(slots[i].rst));
        chk({tag, "_busy"}, 32'(busy_o), 1);
        chk({tag, "_done"}, 32'(done_o), 0);
        hold_mv = slots[i].mv;
    endtask

    task automatic chk_end(input string tag, input int d0);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'(d0 + 1));
        chk({tag, "_end_busy"}, 32'(busy_o), 0);
        chk({tag, "_end_tone_rst"}, 32'(tone_rst_o), 1);
        chk({tag, "_end_maxval"}, 32'(maxval_o), 32'(hold_mv));
    endtask

    task automatic do_stop(input string tag, input int d0);
        @(posedge clk_i); #1;
        stop_i = 1'b1; tick_i = 1'b1;
        @(posedge clk_i); #1;
        tick_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_stop_done"}, 32'(done_o), 1);
        chk({tag, "_stop_busy"}, 32'(busy_o), 0);
        chk({tag, "_stop_tone_rst"}, 32'(tone_rst_o), 1);
        chk({tag, "_stop_maxval"}, 32'(maxval_o), 32'(hold_mv));
        stop_i = 1'b0;
        settle();
        chk({tag, "_stop_done_count"}, 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic run(input string tag, input bit lp, input int stop_at, input int limit, input bit ovw);
        int d0;
        build(lp, limit);
        d0 = done_cnt;
        loop_i = lp;
        $display("run %s: loop=%0d slots=%0d ends=%0d stop_at=%0d", tag, lp, slots.size(), ends, stop_at);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        settle();
        if (slots.size() == 0) begin
            chk_end(tag, d0);
            return;
        end
        for (int i = 0; i < slots.size(); i++) begin
            chk_slot(tag, i);
            if (ovw && i == 0) wr_raw(slots[0].step, {1'b1, 8'hA5, 12'd7});
            if (i == stop_at || (i == slots.size() - 1 && !ends)) begin
                do_stop(tag, d0);
                return;
            end
            if (i < slots.size() - 1) tick($urandom_range(0, 3) == 0);
        end
        tick(1'b0);
        chk_end(tag, d0);
    endtask

    initial begin
        int d0;
        int r;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_reset("reset");
        reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) wr_step(a, 1'b0, 0, 0);

        // Basic melody, overwriting the playing entry mid-note.
        wr_step(0, 1'b0, 100, 3);
        wr_step(1, 1'b1, int'($urandom_range(0, 255)), 2);
        wr_step(2, 1'b0, 50, 1);
        wr_step(3, 1'b0, 0, 0);
        run("t1", 1'b0, -1, 64, 1'b1);
        wr_step(0, 1'b0, 100, 3);

        // Looping, stopped mid-note on the second pass of step 0.
        run("t2", 1'b1, 7, 64, 1'b0);

        // End marker at step 0 with loop enabled.
        wr_step(0, 1'b0, 77, 0);
        run("t3", 1'b1, -1, 64, 1'b0);

        // Full table of one-tick notes.
        for (int a = 0; a < DEPTH; a++) wr_step(a, 1'b0, 16 + a * 13, 1);
        run("t4", 1'b0, -1, 64, 1'b0);

        // Reset during PLAY, then replay.
        wr_step(0, 1'b0, 100, 3);
        wr_step(1, 1'b1, 9, 2);
        wr_step(2, 1'b0, 50, 1);
        wr_step(3, 1'b0, 0, 0);
        d0 = done_cnt;
        loop_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        settle();
        chk("t5_pre_maxval", 32'(maxval_o), 100);
        tick(1'b0);
        @(posedge clk_i); #1;
        reset = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk_reset("t5_reset");
        reset = 1'b0;
        hold_mv = 0;
        settle();
        chk("t5_no_done", 32'(done_cnt), 32'(d0));
        run("t5b", 1'b0, -1, 64, 1'b0);

        // start and stop together in IDLE.
        d0 = done_cnt;
        @(posedge clk_i); #1;
        start_i = 1'b1; stop_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; stop_i = 1'b0;
        settle();
        chk("t6_busy", 32'(busy_o), 0);
        chk("t6_tone_rst", 32'(tone_rst_o), 1);
        chk("t6_no_done", 32'(done_cnt), 32'(d0));

        // Randomized tables, loop modes and stop points.
        for (int it = 0; it < 10; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                r = int'($urandom_range(0, 7));
                wr_step(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                        (r == 0) ? 0 : int'($urandom_range(1, 3)));
            end
            r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            run("rnd", 1'($urandom_range(0, 1)), r, 30, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
